// File: rtl/adc_bram_capture.sv
// -----------------------------------------------------------------------------
// adc_bram_capture
//
// Captures pairs of ADC samples (channel 0 / channel 1) into a BRAM through
// port B. A capture is armed by a pulse on arm, started by a rising edge on
// sw_trig or ext_trig, and then writes one 32-bit word per accepted sample
// until the programmed length is reached. Samples are decimated by keeping one
// valid sample in every decim+1.
//
// Optional feature macro: ADC_THRESH_TRIG_EN
//   When defined, a rising crossing of signed adc0 through thresh also starts
//   the capture. When undefined, thresh is ignored.
//
// Parameters
//   BRAM_ADDR   BRAM word-address width; capture depth is 2^BRAM_ADDR words
//   DATA_WIDTH  per-channel sample width, two's complement (at most 16)
//
// Ports
//   clk, aresetn          clock, asynchronous active-low reset
//   adc0, adc1, adc_valid sample inputs and their valid strobe
//   arm, abort            single-cycle control pulses
//   sw_trig, ext_trig     trigger levels, edge-detected internally
//   capture_len, decim    capture length (0 = full depth) and decimation
//   thresh                channel-0 trigger level
//   bram_addr/din/en/we   BRAM port B write interface (byte address)
//   armed, busy, finish   status flags
//   words_written         words committed in the current or last capture
// -----------------------------------------------------------------------------
module adc_bram_capture #(
    parameter int unsigned BRAM_ADDR  = 11,
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] adc0,
    input  logic [DATA_WIDTH-1:0] adc1,
    input  logic                  adc_valid,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sw_trig,
    input  logic                  ext_trig,
    input  logic [BRAM_ADDR:0]    capture_len,
    input  logic [15:0]           decim,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic [31:0]           bram_addr,
    output logic [31:0]           bram_din,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic                  armed,
    output logic                  busy,
    output logic                  finish,
    output logic [BRAM_ADDR:0]    words_written
);

    localparam logic [BRAM_ADDR:0] MaxLen = {1'b1, {BRAM_ADDR{1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [BRAM_ADDR:0] len_q;
    logic [15:0]        decim_q;
    logic [15:0]        dec_cnt_q;
    logic               sw_trig_q;
    logic               ext_trig_q;
    logic [BRAM_ADDR:0] eff_len;
    logic               trig_edge;
    logic               accept;
    logic               arm_ok;
    logic               thresh_cross;

`ifdef ADC_THRESH_TRIG_EN
    // Last adc0 seen with adc_valid, for detecting an upward crossing.
    logic [DATA_WIDTH-1:0] prev_adc0_q;

    assign thresh_cross = adc_valid
                          && ($signed(adc0) >= $signed(thresh))
                          && ($signed(prev_adc0_q) < $signed(thresh));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            prev_adc0_q <= '0;
        end else if (adc_valid) begin
            prev_adc0_q <= adc0;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign thresh_cross  = 1'b0;
`endif

    always_comb begin
        // 0 or anything beyond the depth means a full-depth capture.
        eff_len = capture_len;
        if (capture_len == '0 || capture_len > MaxLen) begin
            eff_len = MaxLen;
        end

        trig_edge = (sw_trig & ~sw_trig_q) | (ext_trig & ~ext_trig_q) | thresh_cross;
        arm_ok    = arm && (state_q == StIdle || state_q == StDone);

        // words_written < len_q keeps the word index below 2^BRAM_ADDR.
        accept = (state_q == StCapture) && adc_valid && (dec_cnt_q == '0)
                 && (words_written < len_q) && !abort;

        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (arm) state_d = StArmed;
                StArmed:   if (trig_edge) state_d = StCapture;
                StCapture: if (words_written == len_q) state_d = StDone;
                StDone:    if (arm) state_d = StArmed;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            len_q         <= '0;
            decim_q       <= '0;
            dec_cnt_q     <= '0;
            sw_trig_q     <= 1'b0;
            ext_trig_q    <= 1'b0;
            bram_addr     <= '0;
            bram_din      <= '0;
            bram_en       <= 1'b0;
            bram_we       <= '0;
            armed         <= 1'b0;
            busy          <= 1'b0;
            finish        <= 1'b0;
            words_written <= '0;
        end else begin
            // Edge detectors run in every state so a level already high at
            // arm time cannot start a capture.
            sw_trig_q  <= sw_trig;
            ext_trig_q <= ext_trig;

            state_q <= state_d;
            armed   <= (state_d == StArmed);
            busy    <= (state_d == StArmed) || (state_d == StCapture);
            finish  <= (state_d == StDone);

            bram_en <= 1'b0;
            bram_we <= 4'h0;

            if (abort) begin
                words_written <= '0;
            end else begin
                if (arm_ok) begin
                    words_written <= '0;
                    len_q         <= eff_len;
                    decim_q       <= decim;
                end

                if (state_q == StArmed && trig_edge) begin
                    dec_cnt_q <= '0;
                end else if (state_q == StCapture && adc_valid) begin
                    dec_cnt_q <= (dec_cnt_q == decim_q) ? 16'd0 : dec_cnt_q + 16'd1;
                end

                if (accept) begin
                    bram_en       <= 1'b1;
                    bram_we       <= 4'hF;
                    bram_addr     <= {{(30 - BRAM_ADDR){1'b0}},
                                      words_written[BRAM_ADDR-1:0], 2'b00};
                    bram_din      <= {16'($signed(adc1)), 16'($signed(adc0))};
                    words_written <= words_written + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_bram_capture.sv
module tb_adc_bram_capture;

    localparam int BA = 4;
    localparam int DW = 14;
    localparam int DEPTH = 1 << BA;

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] adc0;
    logic [DW-1:0] adc1;
    logic          adc_valid;
    logic          arm;
    logic          abort;
    logic          sw_trig;
    logic          ext_trig;
    logic [BA:0]   capture_len;
    logic [15:0]   decim;
    logic [DW-1:0] thresh;
    logic [31:0]   bram_addr;
    logic [31:0]   bram_din;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic          armed;
    logic          busy;
    logic          finish;
    logic [BA:0]   words_written;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          c;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
    } wr_t;

    wr_t obs[$];
    wr_t exp_q[$];

    adc_bram_capture #(
        .BRAM_ADDR  (BA),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .adc0          (adc0),
        .adc1          (adc1),
        .adc_valid     (adc_valid),
        .arm           (arm),
        .abort         (abort),
        .sw_trig       (sw_trig),
        .ext_trig      (ext_trig),
        .capture_len   (capture_len),
        .decim         (decim),
        .thresh        (thresh),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_en       (bram_en),
        .bram_we       (bram_we),
        .armed         (armed),
        .busy          (busy),
        .finish        (finish),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write cycle seen on the BRAM port is logged with its cycle number.
    always @(negedge clk) begin
        if (aresetn && bram_en) obs.push_back('{cyc, bram_addr, bram_din, bram_we});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word: each channel sign-extended to 16 bits as a signed integer.
    function automatic logic [31:0] pack(input logic [DW-1:0] a0, input logic [DW-1:0] a1);
        int s0;
        int s1;
        s0 = int'($signed(a0));
        s1 = int'($signed(a1));
        return {s1[15:0], s0[15:0]};
    endfunction

    task automatic compare_writes(input string name);
        n_checks++;
        if (obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write count: got %0d expected %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs[i].c !== exp_q[i].c || obs[i].addr !== exp_q[i].addr
                || obs[i].din !== exp_q[i].din || obs[i].we !== exp_q[i].we) begin
                n_fail++;
                $display("FAIL %s write %0d: got cyc=%0d addr=%h din=%h we=%h expected cyc=%0d addr=%h din=%h we=%h",
                         name, i, obs[i].c, obs[i].addr, obs[i].din, obs[i].we,
                         exp_q[i].c, exp_q[i].addr, exp_q[i].din, exp_q[i].we);
            end
        end
    endtask

    task automatic check_flags(input string name, input logic e_armed, input logic e_busy,
                               input logic e_finish, input int e_ww);
        n_checks++;
        if (armed !== e_armed || busy !== e_busy || finish !== e_finish
            || words_written !== (BA + 1)'(e_ww)) begin
            n_fail++;
            $display("FAIL %s flags: got armed=%b busy=%b finish=%b ww=%0d expected armed=%b busy=%b finish=%b ww=%0d",
                     name, armed, busy, finish, words_written, e_armed, e_busy, e_finish, e_ww);
        end
    endtask

    task automatic arm_with(input int len_in, input int dec);
        capture_len = (BA + 1)'(len_in);
        decim       = 16'(dec);
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
        // Later changes must not affect the capture in progress.
        capture_len = (BA + 1)'($urandom);
        decim       = 16'($urandom);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 32'h0 || bram_din !== 32'h0) begin
            n_fail++;
            $display("FAIL reset bram: got en=%b we=%h addr=%h din=%h expected all zero",
                     bram_en, bram_we, bram_addr, bram_din);
        end
        check_flags("reset", 1'b0, 1'b0, 1'b0, 0);
        aresetn = 1'b1;
        tick();
        check_flags("after reset", 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Random capture checked against a list of expected writes built from the
    // rule "keep valid samples whose index since the trigger is a multiple of
    // decim+1, until the effective length is reached".
    task automatic test_random_capture(input string name, input int len_in, input int dec,
                                       input int vprob, input bit use_ext);
        int eff;
        int vidx;
        int budget;
        eff = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
        obs.delete();
        exp_q.delete();
        arm_with(len_in, dec);
        check_flags({name, " armed"}, 1'b1, 1'b1, 1'b0, 0);
        adc_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        if (use_ext) ext_trig = 1'b1;
        else sw_trig = 1'b1;
        adc_valid = 1'($urandom_range(0, 1));
        adc0 = DW'($urandom);
        adc1 = DW'($urandom);
        tick();
        vidx = 0;
        budget = 0;
        while (exp_q.size() < eff && budget < 2000) begin
            adc0      = DW'($urandom);
            adc1      = DW'($urandom);
            adc_valid = ($urandom_range(1, 100) <= vprob);
            sw_trig   = 1'($urandom);
            ext_trig  = 1'($urandom);
            if (adc_valid) begin
                if (vidx % (dec + 1) == 0)
                    exp_q.push_back('{cyc + 1, 32'(exp_q.size() * 4), pack(adc0, adc1), 4'hF});
                vidx++;
            end
            tick();
            budget++;
        end
        n_checks++;
        if (budget >= 2000) begin
            n_fail++;
            $display("FAIL %s stimulus budget: got %0d cycles expected under 2000", name, budget);
        end
        adc_valid = 1'b0;
        sw_trig   = 1'b0;
        ext_trig  = 1'b0;
        repeat (4) tick();
        compare_writes(name);
        check_flags({name, " done"}, 1'b0, 1'b0, 1'b1, eff);
    endtask

    task automatic test_basic_len4();
        obs.delete();
        exp_q.delete();
        arm_with(4, 0);
        adc_valid = 1'b1;
        adc1 = 14'd7;
        adc0 = 14'd100;
        sw_trig = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            adc0 = DW'(i + 1);
            exp_q.push_back('{cyc + 1, 32'(i * 4), {16'd7, 16'(i + 1)}, 4'hF});
            tick();
        end
        repeat (4) tick();
        adc_valid = 1'b0;
        sw_trig = 1'b0;
        tick();
        compare_writes("len4");
        check_flags("len4 done", 1'b0, 1'b0, 1'b1, 4);
    endtask

    task automatic test_decim();
        logic [31:0] want[3];
        want[0] = 32'd1;
        want[1] = 32'd4;
        want[2] = 32'd7;
        obs.delete();
        arm_with(3, 2);
        adc1 = '0;
        adc_valid = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            adc0 = DW'(i);
            sw_trig = (i == 0);
            tick();
        end
        adc_valid = 1'b0;
        sw_trig = 1'b0;
        tick();
        n_checks++;
        if (obs.size() !== 3) begin
            n_fail++;
            $display("FAIL decim count: got %0d expected 3", obs.size());
        end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i].din !== want[i] || obs[i].addr !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL decim write %0d: got addr=%h din=%h expected addr=%h din=%h",
                         i, obs[i].addr, obs[i].din, 32'(i * 4), want[i]);
            end
        end
        check_flags("decim done", 1'b0, 1'b0, 1'b1, 3);
    endtask

    task automatic test_pack();
        obs.delete();
        arm_with(1, 0);
        adc_valid = 1'b0;
        sw_trig = 1'b1;
        tick();
        adc0 = '1;
        adc1 = 14'd5;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        sw_trig = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (obs.size() !== 1 || obs[0].din !== 32'h0005FFFF) begin
            n_fail++;
            $display("FAIL pack: got count=%0d din=%h expected count=1 din=0005ffff",
                     obs.size(), (obs.size() > 0) ? obs[0].din : 32'hx);
        end
    endtask

    task automatic test_full_depth();
        test_random_capture("full0", 0, 0, 100, 1'b0);
        n_checks++;
        if (obs.size() == 0 || obs[obs.size() - 1].addr !== 32'd60) begin
            n_fail++;
            $display("FAIL full last addr: got %h expected 0000003c",
                     (obs.size() > 0) ? obs[obs.size() - 1].addr : 32'hx);
        end
        test_random_capture("full31", 31, 1, 80, 1'b1);
    endtask

    task automatic test_abort();
        obs.delete();
        arm_with(8, 0);
        adc_valid = 1'b0;
        sw_trig = 1'b1;
        tick();
        adc_valid = 1'b1;
        repeat (2) begin
            adc0 = DW'($urandom);
            tick();
        end
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        repeat (10) begin
            sw_trig = 1'($urandom);
            tick();
        end
        adc_valid = 1'b0;
        sw_trig = 1'b0;
        tick();
        n_checks++;
        if (obs.size() !== 2) begin
            n_fail++;
            $display("FAIL abort write count: got %0d expected 2", obs.size());
        end
        check_flags("abort idle", 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_ext_held();
        obs.delete();
        ext_trig = 1'b1;
        repeat (2) tick();
        arm_with(2, 0);
        adc0 = '0;
        adc_valid = 1'b1;
        repeat (3) tick();
        // arm while ARMED must not reload the length
        capture_len = 5'd5;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (obs.size() !== 0 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL ext held: got writes=%0d armed=%b expected writes=0 armed=1",
                     obs.size(), armed);
        end
        ext_trig = 1'b0;
        tick();
        ext_trig = 1'b1;
        tick();
        repeat (8) tick();
        adc_valid = 1'b0;
        ext_trig = 1'b0;
        tick();
        n_checks++;
        if (obs.size() !== 2) begin
            n_fail++;
            $display("FAIL ext retrig count: got %0d expected 2", obs.size());
        end
        check_flags("ext done", 1'b0, 1'b0, 1'b1, 2);
        arm_with(3, 0);
        check_flags("rearm from done", 1'b1, 1'b1, 1'b0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_thresh();
        obs.delete();
        thresh = 14'd100;
        arm_with(2, 0);
        adc_valid = 1'b1;
        adc0 = 14'd50;
        tick();
        adc0 = 14'd99;
        tick();
        adc0 = 14'd100;
        tick();
        adc0 = 14'd0;
        repeat (5) tick();
        adc_valid = 1'b0;
        tick();
`ifdef ADC_THRESH_TRIG_EN
        n_checks++;
        if (obs.size() !== 2 || finish !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh trigger: got writes=%0d finish=%b expected writes=2 finish=1",
                     obs.size(), finish);
        end
`else
        n_checks++;
        if (obs.size() !== 0 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh ignored: got writes=%0d armed=%b expected writes=0 armed=1",
                     obs.size(), armed);
        end
`endif
        thresh = 14'h1FFF;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_midcapture();
        arm_with(8, 0);
        sw_trig = 1'b1;
        tick();
        adc_valid = 1'b1;
        repeat (2) tick();
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (bram_en !== 1'b0 || bram_we !== 4'h0 || bram_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async reset bram: got en=%b we=%h addr=%h expected 0 0 0",
                     bram_en, bram_we, bram_addr);
        end
        check_flags("async reset", 1'b0, 1'b0, 1'b0, 0);
        adc_valid = 1'b0;
        sw_trig = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        check_flags("reset released", 1'b0, 1'b0, 1'b0, 0);
        test_random_capture("fresh", 2, 0, 100, 1'b0);
    endtask

    initial begin
        aresetn     = 1'b0;
        adc0        = '0;
        adc1        = '0;
        adc_valid   = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        sw_trig     = 1'b0;
        ext_trig    = 1'b0;
        capture_len = '0;
        decim       = '0;
        thresh      = 14'h1FFF;

        test_reset();
        test_basic_len4();
        test_decim();
        test_pack();
        test_full_depth();
        test_abort();
        test_ext_held();
        test_thresh();
        for (int i = 0; i < 6; i++) begin
            test_random_capture("random", int'($urandom_range(0, 20)),
                                int'($urandom_range(0, 3)), int'($urandom_range(40, 100)),
                                1'($urandom));
        end
        test_reset_midcapture();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_bram_capture.md
ADC_BRAM_CAPTURE -- requirements
Module: adc_bram_capture

Interface
REQ-001 Parameter BRAM_ADDR, default 11: BRAM word-address width; capture depth is 2^BRAM_ADDR words.
REQ-002 Parameter DATA_WIDTH, default 14: per-channel ADC sample width, two's complement.
REQ-003 clk  in  1  single clock, same domain as BRAM port B and the AXI-Lite register block.
REQ-004 aresetn  in  1  asynchronous active-low reset.
REQ-005 adc0, adc1  in  DATA_WIDTH each  channel 0 and channel 1 samples.
REQ-006 adc_valid  in  1  samples valid this cycle.
REQ-007 arm  in  1  single-cycle pulse that starts a capture sequence.
REQ-008 abort  in  1  single-cycle pulse that forces a return to IDLE.
REQ-009 sw_trig, ext_trig  in  1 each  software trigger and external trigger; both are level inputs, edge-detected internally.
REQ-010 capture_len  in  BRAM_ADDR+1  number of words to write; 0 or any value above 2^BRAM_ADDR is treated as 2^BRAM_ADDR.
REQ-011 decim  in  16  keep one valid sample in every decim+1.
REQ-012 thresh  in  DATA_WIDTH  channel-0 trigger level (used only under REQ-031).
REQ-013 bram_addr  out  32  byte address, equal to word index << 2.
REQ-014 bram_din  out  32  {sign-extended adc1 in [31:16], sign-extended adc0 in [15:0]}.
REQ-015 bram_en, bram_we  out  1, 4  BRAM port enable and byte write enables.
REQ-016 armed, busy, finish  out  1 each  status flags.
REQ-017 words_written  out  BRAM_ADDR+1  count of words committed in the current or last capture.

Function
REQ-018 The FSM shall use the states IDLE, ARMED, CAPTURE and DONE.
- IDLE -> ARMED on arm.
- ARMED -> CAPTURE on the first rising edge of sw_trig or ext_trig.
- CAPTURE -> DONE when words_written reaches the effective length.
- DONE -> ARMED on arm.
REQ-019 The block shall sample capture_len and decim when arm is accepted and hold them constant until the next arm.
REQ-020 The trigger edge detector shall register sw_trig and ext_trig every cycle in all states, so that a level that is already high when ARMED is entered does not trigger.
REQ-021 In CAPTURE, the decimation counter shall start at 0 on entry; a sample is accepted when adc_valid is high and the counter equals 0. The counter increments on each adc_valid and wraps to 0 after reaching decim.
REQ-022 An accepted sample shall produce exactly one write on the following cycle: bram_en=1, bram_we=4'hF, bram_din packed from the registered sample, bram_addr=words_written<<2 with the pre-increment value. words_written increments on that same cycle.
REQ-023 Outside a write cycle, the block shall drive bram_en=0 and bram_we=0; bram_addr and bram_din hold their last values.
REQ-024 The block shall enter DONE on the cycle after the final write; writes after the length is reached are impossible.
REQ-025 The word index shall never exceed 2^BRAM_ADDR-1; address wrap-around is prohibited.
REQ-026 Status flags:
- armed=1 only in ARMED.
- busy=1 in ARMED or CAPTURE.
- finish=1 only in DONE and held until the next arm.
REQ-027 arm in ARMED or CAPTURE shall be ignored; arm in IDLE or DONE shall clear words_written to 0.
REQ-028 abort shall have priority over arm and over triggers. It drives IDLE on the next cycle, aborts any write not yet issued, and leaves words_written and finish=0.
REQ-029 When a trigger and adc_valid occur in the same cycle in ARMED, that sample shall not be captured; the first candidate sample is on the following cycle.

Reset
REQ-030 While aresetn is low, the block shall asynchronously force:
- state IDLE;
- every counter, edge-detect register and output to 0, including bram_we=0, bram_en=0, armed=0, busy=0, finish=0.
Reset deassertion in mid-capture is the same as a fresh start.

Configuration
REQ-031 Macro ADC_THRESH_TRIG_EN:
- Defined: ARMED -> CAPTURE also occurs on the first accepted-eligible adc_valid cycle where signed adc0 >= signed thresh and the previous valid adc0 < thresh (rising crossing).
- Undefined: the thresh port still exists but is ignored, and only sw_trig and ext_trig trigger.

Verification
REQ-032 arm, capture_len=4, decim=0, adc_valid constant, sw_trig rising -> four writes at byte addresses 0,4,8,12 on consecutive cycles; finish=1; words_written=4.
REQ-033 decim=2, capture_len=3, adc0 ramp 0..20 -> writes of the values 1,4,7 (trigger at sample 0, which is skipped per REQ-029) at addresses 0,4,8.
REQ-034 adc0=-1, adc1=5 captured -> bram_din=32'h0005FFFF.
REQ-035 capture_len=0, BRAM_ADDR=4 -> exactly 16 writes; last address 60; no write to address 64.
REQ-036 abort after 2 of 8 writes -> IDLE; no further bram_en; finish=0; ext_trig held high before arm gives no trigger until it toggles.
REQ-037 Under ADC_THRESH_TRIG_EN, thresh=100 with adc0 sequence 50,99,100 -> capture starts after the sample of 100; without the macro, no capture occurs.
